// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// =============================================================================
// Module   : mips_pipe_pkg
// Brief    : Shared pipeline constants and IF/ID bundle layout.
// Revision : 1.0
// =============================================================================
package mips_pipe_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0;
    localparam int unsigned WORD_BYTES = 4;

    // IF/ID bundle: {instr, pc_plus4, valid}, valid at bit 0.
    localparam int unsigned IFID_W            = 65;
    localparam int unsigned IFID_VALID_BIT    = 0;
    localparam int unsigned IFID_PC_PLUS4_LSB = 1;
    localparam int unsigned IFID_INSTR_LSB    = 33;

    function automatic logic [IFID_W-1:0] ifid_pack(
        input logic [31:0] instr,
        input logic [31:0] pc_plus4,
        input logic        valid
    );
        return {instr, pc_plus4, valid};
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// =============================================================================
// Module   : if_id_reg
// Brief    : IF/ID pipeline register with hold, bubble and load controls.
// Revision : 1.0
// =============================================================================
module if_id_reg
    import mips_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              hold_i,
    input  logic              bubble_i,
    input  logic [31:0]       instr_i,
    input  logic [31:0]       pc_plus4_i,
    output logic [IFID_W-1:0] if_id_o
);

    logic [IFID_W-1:0] if_id_q;

    // Hold outranks bubble so a stalled ID stage never loses its instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_q <= ifid_pack(NOP_INSTR, 32'h0, 1'b0);
        end else if (hold_i) begin
            if_id_q <= if_id_q;
        end else if (bubble_i) begin
            if_id_q <= ifid_pack(NOP_INSTR, 32'h0, 1'b0);
        end else begin
            if_id_q <= ifid_pack(instr_i, pc_plus4_i, 1'b1);
        end
    end

    assign if_id_o = if_id_q;

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// =============================================================================
// Module   : if_fetch_stage
// Brief    : MIPS IF stage: PC, redirect priority mux, IF/ID register.
//            Optional perf counters enabled by macro IF_PERF_CNT_EN.
// Revision : 1.0
// =============================================================================
module if_fetch_stage
    import mips_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] PC_STEP  = 32'(WORD_BYTES)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_en,
    input  logic [31:0] jump_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt,
`endif
    output logic        if_id_valid
);

    logic [31:0]       pc_q;
    logic [31:0]       pc_d;
    logic [31:0]       pc_plus4;
    logic              hold;
    logic              bubble;
    logic [IFID_W-1:0] if_id_bus;

    assign pc_plus4  = pc_q + PC_STEP;
    assign imem_addr = pc_q;

    // The branch in EX is older than the stalled instruction, so it beats stall.
    always_comb begin
        pc_d   = pc_q;
        hold   = 1'b0;
        bubble = 1'b0;
        if (branch_taken) begin
            pc_d   = branch_target;
            bubble = 1'b1;
        end else if (stall) begin
            hold   = 1'b1;
        end else if (jump_en) begin
            pc_d   = jump_target;
            bubble = 1'b1;
        end else if (flush) begin
            pc_d   = pc_plus4;
            bubble = 1'b1;
        end else begin
            pc_d   = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .reset      (reset),
        .hold_i     (hold),
        .bubble_i   (bubble),
        .instr_i    (imem_rdata),
        .pc_plus4_i (pc_plus4),
        .if_id_o    (if_id_bus)
    );

    assign if_id_instr    = if_id_bus[IFID_INSTR_LSB +: 32];
    assign if_id_pc_plus4 = if_id_bus[IFID_PC_PLUS4_LSB +: 32];
    assign if_id_valid    = if_id_bus[IFID_VALID_BIT];

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
        end else begin
            if (!hold && !bubble) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (bubble) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt  = fetch_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// =============================================================================
// Module   : tb_if_fetch_stage
// Brief    : Directed self-checking bench for if_fetch_stage.
// Revision : 1.0
// =============================================================================
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        jump_en = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    logic [31:0] mem [256];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[9:2]];

    if_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump_en        (jump_en),
        .jump_target    (jump_target),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
`ifdef IF_PERF_CNT_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_bubble_cnt(perf_bubble_cnt),
`endif
        .if_id_valid    (if_id_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; jump_en = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        tests++; if (imem_addr !== 32'h0040_0000) begin fails++; $display("FAIL reset_addr got %h want %h", imem_addr, 32'h0040_0000); end
        tests++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", if_id_valid); end
        tests++; if (if_id_instr !== 32'h0) begin fails++; $display("FAIL reset_instr got %h want 0", if_id_instr); end
        tests++; if (if_id_pc_plus4 !== 32'h0) begin fails++; $display("FAIL reset_pc4 got %h want 0", if_id_pc_plus4); end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_instr [4];
        exp_instr[0] = 32'h0000_8021; exp_instr[1] = 32'h0000_8821;
        exp_instr[2] = 32'h8e12_0000; exp_instr[3] = 32'h0012_a021;
        for (int i = 0; i < 4; i++) begin
            tests++; if (imem_addr !== 32'h0040_0000 + 32'(4*i)) begin fails++; $display("FAIL seq_addr[%0d] got %h want %h", i, imem_addr, 32'h0040_0000 + 32'(4*i)); end
            tick();
            tests++; if (if_id_instr !== exp_instr[i]) begin fails++; $display("FAIL seq_instr[%0d] got %h want %h", i, if_id_instr, exp_instr[i]); end
            tests++; if (if_id_pc_plus4 !== 32'h0040_0004 + 32'(4*i)) begin fails++; $display("FAIL seq_pc4[%0d] got %h want %h", i, if_id_pc_plus4, 32'h0040_0004 + 32'(4*i)); end
            tests++; if (if_id_valid !== 1'b1) begin fails++; $display("FAIL seq_valid[%0d] got %b want 1", i, if_id_valid); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick(); tick();
        stall = 1'b1;
        jump_en = 1'b1; jump_target = 32'h0040_0100;
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (imem_addr !== 32'h0040_0008) begin fails++; $display("FAIL stall_addr[%0d] got %h want 00400008", i, imem_addr); end
            tests++; if (if_id_instr !== 32'h0000_8821) begin fails++; $display("FAIL stall_instr[%0d] got %h want 00008821", i, if_id_instr); end
            tests++; if (if_id_pc_plus4 !== 32'h0040_0008) begin fails++; $display("FAIL stall_pc4[%0d] got %h want 00400008", i, if_id_pc_plus4); end
            tests++; if (if_id_valid !== 1'b1) begin fails++; $display("FAIL stall_valid[%0d] got %b want 1", i, if_id_valid); end
        end
        stall = 1'b0; jump_en = 1'b0; flush = 1'b0;
        tick();
        tests++; if (imem_addr !== 32'h0040_000C) begin fails++; $display("FAIL unstall_addr got %h want 0040000c", imem_addr); end
        tests++; if (if_id_instr !== 32'h8e12_0000) begin fails++; $display("FAIL unstall_instr got %h want 8e120000", if_id_instr); end
    endtask

    task automatic test_jump();
        jump_en = 1'b1; jump_target = 32'h0040_00D0;
        tick();
        jump_en = 1'b0;
        tests++; if (imem_addr !== 32'h0040_00D0) begin fails++; $display("FAIL jump_addr got %h want 004000d0", imem_addr); end
        tests++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL jump_valid got %b want 0", if_id_valid); end
        tests++; if (if_id_instr !== 32'h0) begin fails++; $display("FAIL jump_instr got %h want 0", if_id_instr); end
        tick();
        tests++; if (if_id_instr !== 32'hA000_0034) begin fails++; $display("FAIL jump_load_instr got %h want a0000034", if_id_instr); end
        tests++; if (if_id_pc_plus4 !== 32'h0040_00D4) begin fails++; $display("FAIL jump_load_pc4 got %h want 004000d4", if_id_pc_plus4); end
        tests++; if (if_id_valid !== 1'b1) begin fails++; $display("FAIL jump_load_valid got %b want 1", if_id_valid); end
    endtask

    task automatic test_priority();
        branch_taken = 1'b1; branch_target = 32'h0040_0040;
        stall = 1'b1; jump_en = 1'b1; jump_target = 32'h0040_00D0;
        tick();
        branch_taken = 1'b0; stall = 1'b0; jump_en = 1'b0;
        tests++; if (imem_addr !== 32'h0040_0040) begin fails++; $display("FAIL prio_addr got %h want 00400040", imem_addr); end
        tests++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL prio_valid got %b want 0", if_id_valid); end
        tests++; if (if_id_instr !== 32'h0) begin fails++; $display("FAIL prio_instr got %h want 0", if_id_instr); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tests++; if (imem_addr !== 32'h0040_0044) begin fails++; $display("FAIL flush_addr got %h want 00400044", imem_addr); end
        tests++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %b want 0", if_id_valid); end
        tick();
        tests++; if (if_id_instr !== 32'hA000_0011) begin fails++; $display("FAIL post_flush_instr got %h want a0000011", if_id_instr); end
        tests++; if (if_id_valid !== 1'b1) begin fails++; $display("FAIL post_flush_valid got %b want 1", if_id_valid); end
    endtask

    task automatic test_reset_mid_stall();
        stall = 1'b1; jump_en = 1'b1; jump_target = 32'h0040_00D0; reset = 1'b1;
        tick();
        reset = 1'b0; stall = 1'b0; jump_en = 1'b0;
        tests++; if (imem_addr !== 32'h0040_0000) begin fails++; $display("FAIL rst_stall_addr got %h want 00400000", imem_addr); end
        tests++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL rst_stall_valid got %b want 0", if_id_valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        jump_en = 1'b1; jump_target = 32'hFFFF_FFFC;
        tick();
        jump_en = 1'b0;
        tests++; if (imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_jump_addr got %h want fffffffc", imem_addr); end
        tick();
        tests++; if (imem_addr !== 32'h0000_0000) begin fails++; $display("FAIL wrap_addr got %h want 00000000", imem_addr); end
        tests++; if (if_id_pc_plus4 !== 32'h0000_0000) begin fails++; $display("FAIL wrap_pc4 got %h want 00000000", if_id_pc_plus4); end
        tests++; if (if_id_instr !== 32'hA000_00FF) begin fails++; $display("FAIL wrap_instr got %h want a00000ff", if_id_instr); end
        tests++; if (if_id_valid !== 1'b1) begin fails++; $display("FAIL wrap_valid got %b want 1", if_id_valid); end
`ifdef IF_PERF_CNT_EN
        tests++; if (perf_fetch_cnt !== 32'd1) begin fails++; $display("FAIL perf_fetch got %0d want 1", perf_fetch_cnt); end
        tests++; if (perf_bubble_cnt !== 32'd1) begin fails++; $display("FAIL perf_bubble got %0d want 1", perf_bubble_cnt); end
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
        mem[0] = 32'h0000_8021;
        mem[1] = 32'h0000_8821;
        mem[2] = 32'h8e12_0000;
        mem[3] = 32'h0012_a021;
        test_reset();
        test_sequential();
        test_stall();
        test_jump();
        test_priority();
        test_reset_mid_stall();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
